bitrev_pp: RTL and testbench

//  Ping-pong bit-reversal permutation buffer with runtime frame size and mode.

---
 rtl/bitrev_pkg.sv | 30 +++
 rtl/bitrev_pp_if.sv | 28 ++
 rtl/bitrev_bank.sv | 63 ++++++
 rtl/bitrev_pp.sv | 127 ++++++++++++
 tb/tb_bitrev_pp.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bitrev_pp ping-pong bit-reversal buffer.
// Address helpers are written for frame indices up to BR_AW_MAX bits.
package bitrev_pkg;

    typedef enum logic {
        BR_BYPASS = 1'b0,
        BR_BITREV = 1'b1
    } br_mode_e;

    localparam int unsigned BR_AW_MAX = 16;

    // Reverse the low keff bits of a, viewed as a kmax-bit index.
    function automatic logic [BR_AW_MAX-1:0] rev_bits(input logic [BR_AW_MAX-1:0] a,
                                                      input int unsigned keff,
                                                      input int unsigned kmax);
        logic [BR_AW_MAX-1:0] r;
        for (int i = 0; i < BR_AW_MAX; i++) begin
            r[i] = a[BR_AW_MAX-1-i];
        end
        r = r >> (BR_AW_MAX - kmax);
        return r >> (kmax - keff);
    endfunction

    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned kmax);
        if (k < 1) return 1;
        if (k > kmax) return kmax;
        return k;
    endfunction

endpackage

// File: rtl/bitrev_pp_if.sv
// Write-side and read-side stream signals of bitrev_pp, plus per-frame config.
// slave is the buffer's view; master is the source/sink's view.
interface bitrev_pp_if #(
    parameter int KMAX = 10,
    parameter int DW   = 32
) ();
    localparam int KW = $clog2(KMAX + 1);

    logic [KW-1:0] k_i;
    logic          mode_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          ready_i;

    modport slave (
        input  k_i, mode_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, last_o
    );

    modport master (
        output k_i, mode_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/bitrev_bank.sv
// One frame store of the ping-pong pair: flop array, full flag and the
// {keff, mode} captured from the first word of the frame it holds.
module bitrev_bank
    import bitrev_pkg::*;
#(
    parameter int KMAX = 10,
    parameter int DW   = 32,
    parameter int KW   = $clog2(KMAX + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [KMAX-1:0] waddr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic            cfg_we_i,
    input  logic [KW-1:0]   cfg_keff_i,
    input  br_mode_e        cfg_mode_i,
    input  logic            set_full_i,
    input  logic            clr_full_i,
    input  logic [KMAX-1:0] raddr_i,
    output logic            full_o,
    output logic [KW-1:0]   keff_o,
    output br_mode_e        mode_o,
    output logic [DW-1:0]   rdata_o
);

    logic            full_q;
    logic [KW-1:0]   keff_q;
    br_mode_e        mode_q;
    logic [DW-1:0]   mem_q [2**KMAX];

    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            keff_q <= '0;
            mode_q <= BR_BYPASS;
        end else begin
            if (set_full_i) begin
                full_q <= 1'b1;
            end else if (clr_full_i) begin
                full_q <= 1'b0;
            end
            if (cfg_we_i) begin
                keff_q <= cfg_keff_i;
                mode_q <= cfg_mode_i;
            end
        end
    end

    // NOTE: the sample store has no reset; full_q gates every read of it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign full_o  = full_q;
    assign keff_o  = keff_q;
    assign mode_o  = mode_q;
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bitrev_pp.sv
// Ping-pong bit-reversal buffer: frames in natural order, out bit-reversed or
// unchanged. Define BITREV_FRAME_CNT_EN to add the frame_cnt_o counter port.
module bitrev_pp
    import bitrev_pkg::*;
#(
    parameter int KMAX = 10,
    parameter int DW   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    bitrev_pp_if.slave  bus
`ifdef BITREV_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt_o
`endif
);

    localparam int KW = $clog2(KMAX + 1);

    logic            wb_q, wb_d, rb_q, rb_d;
    logic [KMAX-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

    logic            bank_full [2];
    logic [KW-1:0]   bank_keff [2];
    br_mode_e        bank_mode [2];
    logic [DW-1:0]   bank_rdata [2];

    logic            ready, valid, last;
    logic            wr_fire, rd_fire, wr_last;
    logic [KW-1:0]   wkeff;
    logic [KMAX-1:0] raddr;

    function automatic logic [KMAX-1:0] frame_mask(input logic [KW-1:0] keff);
        return KMAX'((32'd1 << keff) - 32'd1);
    endfunction

    // The first word of a frame sizes itself from k_i; later words use the latch.
    assign wkeff   = (wcnt_q == '0) ? KW'(clamp_k(32'(bus.k_i), KMAX)) : bank_keff[wb_q];
    assign wr_last = (wcnt_q == frame_mask(wkeff));
    assign ready   = !bank_full[wb_q] && !rst_i;
    assign wr_fire = bus.valid_i && ready;

    assign raddr   = (bank_mode[rb_q] == BR_BITREV)
                   ? KMAX'(rev_bits(16'(rcnt_q), 32'(bank_keff[rb_q]), KMAX))
                   : rcnt_q;
    assign valid   = bank_full[rb_q];
    assign last    = valid && (rcnt_q == frame_mask(bank_keff[rb_q]));
    assign rd_fire = valid && bus.ready_i;

    assign bus.ready_o = ready;
    assign bus.valid_o = valid;
    assign bus.last_o  = last;
    assign bus.data_o  = valid ? bank_rdata[rb_q] : '0;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        bitrev_bank #(.KMAX(KMAX), .DW(DW), .KW(KW)) u_bank (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .we_i       (wr_fire && (wb_q == 1'(g))),
            .waddr_i    (wcnt_q),
            .wdata_i    (bus.data_i),
            .cfg_we_i   (wr_fire && (wcnt_q == '0) && (wb_q == 1'(g))),
            .cfg_keff_i (wkeff),
            .cfg_mode_i (br_mode_e'(bus.mode_i)),
            .set_full_i (wr_fire && wr_last && (wb_q == 1'(g))),
            .clr_full_i (rd_fire && last && (rb_q == 1'(g))),
            .raddr_i    (raddr),
            .full_o     (bank_full[g]),
            .keff_o     (bank_keff[g]),
            .mode_o     (bank_mode[g]),
            .rdata_o    (bank_rdata[g])
        );
    end

    // NOTE: every _d takes its hold value first so no path infers a latch.
    always_comb begin
        wcnt_d = wcnt_q;
        wb_d   = wb_q;
        rcnt_d = rcnt_q;
        rb_d   = rb_q;
        if (wr_fire) begin
            if (wr_last) begin
                wcnt_d = '0;
                wb_d   = ~wb_q;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
        if (rd_fire) begin
            if (last) begin
                rcnt_d = '0;
                rb_d   = ~rb_q;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt_q <= '0;
            wb_q   <= 1'b0;
            rcnt_q <= '0;
            rb_q   <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            wb_q   <= wb_d;
            rcnt_q <= rcnt_d;
            rb_q   <= rb_d;
        end
    end

`ifdef BITREV_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
        end else if (rd_fire && last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_bitrev_pp.sv
// Self-checking bench for bitrev_pp: frame table plus hand-written corner
// sequences, with a scoreboard of expected output words.
module tb_bitrev_pp;

    localparam int KMAX = 10;
    localparam int DW   = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    bitrev_pp_if #(.KMAX(KMAX), .DW(DW)) bus ();

`ifdef BITREV_FRAME_CNT_EN
    logic [15:0] frame_cnt_o;
`endif

    bitrev_pp #(.KMAX(KMAX), .DW(DW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
`ifdef BITREV_FRAME_CNT_EN
        ,
        .frame_cnt_o (frame_cnt_o)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        logic [3:0] k;
        logic       mode;
        int         base;
        int         len;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int rev_model(input int a, input int kb);
        int r = 0;
        for (int b = 0; b < kb; b++) begin
            if (((a >> b) & 1) != 0) r |= (1 << (kb - 1 - b));
        end
        return r;
    endfunction

    // Read-side ready: random back-pressure or a directly requested level.
    logic bp_en = 1'b0;
    logic rdy_req = 1'b1;
    always @(posedge clk_i) begin
        #2;
        bus.ready_i = bp_en ? ($urandom_range(0, 3) != 0) : rdy_req;
    end

    int cyc = 0;
    int rd_hs = 0;
    int first_rd = -1;
    int last_rd = -1;

    always @(negedge clk_i) begin
        cyc++;
        if (!rst_i && bus.valid_o && bus.ready_i) begin
            rd_hs++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            check("out_expected", longint'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_data", bus.data_o, mon_e.data);
                check("out_last", bus.last_o, mon_e.last);
            end
        end
    end

    int   stall_cnt = 0;
    logic vo_at_last = 1'b0;

    // Called at posedge+1; returns at posedge+1 after the last accepted word.
    task automatic send_frame(input logic [3:0] k, input logic mode, input int base,
                              input int len, input int nwords, input bit push);
        bit hs;
        int n;
        if (push) begin
            for (int i = 0; i < len; i++) begin
                exp_t e;
                int   a;
                a = mode ? rev_model(i, $clog2(len)) : i;
                e.data = DW'(base + a);
                e.last = (i == len - 1);
                sb.push_back(e);
            end
        end
        for (int j = 0; j < nwords; j++) begin
            bus.valid_i = 1'b1;
            bus.data_i  = DW'(base + j);
            bus.k_i     = (j == 0) ? k : 4'(j * 7);
            bus.mode_i  = (j == 0) ? mode : ~mode;
            hs = 1'b0;
            n  = 0;
            while (!hs) begin
                @(negedge clk_i);
                hs = bus.ready_o;
                if (!hs) stall_cnt++;
                if (hs && j == len - 1) vo_at_last = bus.valid_o;
                @(posedge clk_i);
                #1;
                n++;
                if (!hs && n > 5000) begin
                    check("write_accept", hs, 1);
                    bus.valid_i = 1'b0;
                    return;
                end
            end
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.valid_o) && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        check("drain_valid_low", bus.valid_o, 0);
        @(posedge clk_i);
        #1;
    endtask

    vec_t vt[8];
    int   h0;

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.k_i     = '0;
        bus.mode_i  = 1'b0;

        vt = '{
            '{k: 4'd10, mode: 1'b1, base: 0,    len: 1024},
            '{k: 4'd4,  mode: 1'b0, base: 0,    len: 16},
            '{k: 4'd0,  mode: 1'b1, base: 50,   len: 2},
            '{k: 4'd15, mode: 1'b1, base: 5000, len: 1024},
            '{k: 4'd1,  mode: 1'b0, base: 7,    len: 2},
            '{k: 4'd2,  mode: 1'b1, base: 300,  len: 4},
            '{k: 4'd3,  mode: 1'b0, base: 400,  len: 8},
            '{k: 4'd5,  mode: 1'b1, base: 1000, len: 32}
        };

        repeat (3) @(negedge clk_i);
        check("rst_ready_o", bus.ready_o, 0);
        check("rst_valid_o", bus.valid_o, 0);
        check("rst_last_o", bus.last_o, 0);
        check("rst_data_o", bus.data_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_ready_o", bus.ready_o, 1);
        check("post_rst_valid_o", bus.valid_o, 0);
`ifdef BITREV_FRAME_CNT_EN
        check("frame_cnt_reset", frame_cnt_o, 0);
`endif
        @(posedge clk_i);
        #1;

        // k=3 BITREV: output order and one-cycle write-to-valid latency.
        send_frame(4'd3, 1'b1, 0, 8, 8, 1'b1);
        check("valid_before_last_write", vo_at_last, 0);
        @(negedge clk_i);
        check("valid_after_last_write", bus.valid_o, 1);
        drain();

        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_frame(vt[i].k, vt[i].mode, vt[i].base, vt[i].len, vt[i].len, 1'b1);
        end
        drain();
        bp_en = 1'b0;

        // Back-to-back frames of differing size and mode, then a steady burst.
        stall_cnt = 0;
        send_frame(4'd2, 1'b1, 10, 4, 4, 1'b1);
        send_frame(4'd3, 1'b0, 20, 8, 8, 1'b1);
        check("ab_write_stalls", stall_cnt, 0);
        drain();

        stall_cnt = 0;
        first_rd  = -1;
        h0        = rd_hs;
        for (int f = 0; f < 4; f++) begin
            send_frame(4'd2, f[0], 100 * f, 4, 4, 1'b1);
        end
        drain();
        check("steady_write_stalls", stall_cnt, 0);
        check("steady_read_count", rd_hs - h0, 16);
        check("steady_read_span", last_rd - first_rd + 1, 16);

        // Both banks full with the sink stalled, then release.
        rdy_req = 1'b0;
        send_frame(4'd2, 1'b1, 500, 4, 4, 1'b1);
        send_frame(4'd2, 1'b0, 600, 4, 4, 1'b1);
        @(negedge clk_i);
        check("full_ready_low", bus.ready_o, 0);
        check("full_valid_high", bus.valid_o, 1);
        @(posedge clk_i);
        #1;
        rdy_req = 1'b1;
        repeat (4) @(negedge clk_i);
        check("ready_low_before_4th_read", bus.ready_o, 0);
        @(negedge clk_i);
        check("ready_high_after_4th_read", bus.ready_o, 1);
        drain();

        // Reset with one full frame and a partial frame buffered.
        rdy_req = 1'b0;
        send_frame(4'd2, 1'b1, 700, 4, 4, 1'b1);
        send_frame(4'd3, 1'b1, 800, 8, 5, 1'b0);
        rst_i = 1'b1;
        sb.delete();
        @(negedge clk_i);
        check("midrst_ready_o", bus.ready_o, 0);
        check("midrst_valid_o", bus.valid_o, 0);
        check("midrst_last_o", bus.last_o, 0);
        check("midrst_data_o", bus.data_o, 0);
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        rdy_req = 1'b1;
        @(negedge clk_i);
        check("midrst_release_ready_o", bus.ready_o, 1);
        check("midrst_release_valid_o", bus.valid_o, 0);
`ifdef BITREV_FRAME_CNT_EN
        check("frame_cnt_after_reset", frame_cnt_o, 0);
`endif
        @(posedge clk_i);
        #1;
        send_frame(4'd3, 1'b1, 0, 8, 8, 1'b1);
        drain();
`ifdef BITREV_FRAME_CNT_EN
        check("frame_cnt_one_frame", frame_cnt_o, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
